// File: rtl/reaction_pkg.sv
// Shared types, segment codes and helpers for the reaction-time display.
package reaction_pkg;

  localparam int unsigned TW_DEFAULT = 10;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always dark.
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;

  // BCD digit to segment pattern; non-decimal nibbles show a dash.
  function automatic logic [7:0] seg7(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: TW cycles, one source bit per cycle, MSB first.
module bin2bcd_seq
  import reaction_pkg::*;
#(
  parameter int unsigned TW = TW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [TW-1:0] value_i,
  output logic [11:0]   bcd_o,
  output logic          done_o
);

  localparam int unsigned CntW = $clog2(TW + 1);

  logic [TW-1:0]   sh_q;
  logic [11:0]     bcd_q;
  logic [CntW-1:0] cnt_q;
  logic            run_q;
  logic [11:0]     adj;
  logic            last_shift;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign last_shift = run_q && (cnt_q == CntW'(TW - 1));

  // Load on start, then shift the corrected BCD and source together each cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      sh_q  <= value_i;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      {bcd_q, sh_q} <= {adj[10:0], sh_q, 1'b0};
      cnt_q         <= cnt_q + 1'b1;
      if (last_shift) run_q <= 1'b0;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = last_shift;

endmodule

// File: rtl/reaction_display.sv
// Captures reaction times, tracks the best, and shows last/best on HEX1/HEX0.
module reaction_display
  import reaction_pkg::*;
#(
  parameter int unsigned TW       = TW_DEFAULT,
  parameter int unsigned MAX_SHOW = 999
) (
  input  logic          CLK_50,
  input  logic          RESET_N,
  input  logic [TW-1:0] iTIMER,
  input  logic          iDONE,
  input  logic          iSHOW_BEST,
  output logic          oBUSY,
  output logic          oNEW_BEST,
  output logic [7:0]    HEX1,
  output logic [7:0]    HEX0
);

  state_e        state_q;
  logic [TW-1:0] last_q;
  logic [TW-1:0] best_q;
  logic          pend_q;
  logic          show_q;
  logic          new_best_q;
  logic          over_q;
  logic [7:0]    hex1_q;
  logic [7:0]    hex0_q;
  logic          req;
  logic [TW-1:0] src;
  logic [11:0]   bcd;
  logic          conv_done;
  logic          unused_ones;

  assign req = iDONE | (iSHOW_BEST ^ show_q);
  assign src = iSHOW_BEST ? best_q : last_q;

  // Capture last time, track best, and remember the show level for edge detection.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      last_q     <= '0;
      best_q     <= '1;
      show_q     <= 1'b0;
      new_best_q <= 1'b0;
    end else begin
      show_q     <= iSHOW_BEST;
      new_best_q <= iDONE && (iTIMER < best_q);
      if (iDONE) begin
        last_q <= iTIMER;
        if (iTIMER < best_q) best_q <= iTIMER;
      end
    end
  end

  // Conversion sequencer with registered segment outputs.
  // The pending flag is consumed when its conversion starts, so requests arriving
  // anywhere in LOAD..DONE coalesce into exactly one follow-up conversion.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      over_q  <= 1'b0;
      hex1_q  <= SEG_DASH;
      hex0_q  <= SEG_DASH;
    end else begin
      case (state_q)
        StIdle: begin
          if (req || pend_q) begin
            state_q <= StLoad;
            pend_q  <= 1'b0;
          end
        end
        StLoad: begin
          if (req) pend_q <= 1'b1;
          over_q  <= 32'(src) > MAX_SHOW;
          state_q <= StShift;
        end
        StShift: begin
          if (req) pend_q <= 1'b1;
          if (conv_done) state_q <= StDone;
        end
        StDone: begin
          if (req) pend_q <= 1'b1;
          hex1_q  <= over_q ? SEG_DASH : seg7(bcd[11:8]);
          hex0_q  <= over_q ? SEG_DASH : seg7(bcd[7:4]);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  bin2bcd_seq #(
    .TW (TW)
  ) u_bcd (
    .clk_i   (CLK_50),
    .rst_ni  (RESET_N),
    .start_i (state_q == StLoad),
    .value_i (src),
    .bcd_o   (bcd),
    .done_o  (conv_done)
  );

  // Milliseconds are truncated from the display.
  assign unused_ones = ^bcd[3:0];

  assign oBUSY     = (state_q != StIdle);
  assign oNEW_BEST = new_best_q;
  assign HEX1      = hex1_q;
  assign HEX0      = hex0_q;

endmodule
